// File: rtl/aes_pkg.sv
// Shared AES constants and helpers:
// mode codes, per-mode key/round counts, xtime.
package aes_pkg;

  localparam logic [1:0] AES_128 = 2'b00;
  localparam logic [1:0] AES_192 = 2'b01;
  localparam logic [1:0] AES_256 = 2'b10;

  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GEN,
    ST_DONE
  } ks_state_t;

  function automatic logic [3:0] nk_of(
    input logic [1:0] mode
  );
    case (mode)
      AES_128: return 4'd4;
      AES_192: return 4'd6;
      AES_256: return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(
    input logic [1:0] mode
  );
    case (mode)
      AES_128: return 4'd10;
      AES_192: return 4'd12;
      AES_256: return 4'd14;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: GF(2^8) inverse
// (x^254) followed by the affine transform.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] s
);

  function automatic logic [7:0] gmul(
    input logic [7:0] x,
    input logic [7:0] y
  );
    logic [7:0] p;
    logic [7:0] m;
    p = 8'h00;
    m = x;
    for (int b = 0; b < 8; b++) begin
      if (y[b]) p = p ^ m;
      m = xtime(m);
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // inverse as x^(2+4+...+128); zero maps to zero
  always_comb begin
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
  end

  assign s = inv
           ^ {inv[6:0], inv[7]}
           ^ {inv[5:0], inv[7:6]}
           ^ {inv[4:0], inv[7:5]}
           ^ {inv[3:0], inv[7:4]}
           ^ 8'h63;

endmodule

// File: rtl/aes_key_schedule.sv
// AES-128/192/256 key expansion, one word per
// cycle, round keys written as 128-bit strobes.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int MAX_NK    = 8,
  parameter int ADDR_W    = 4,
  parameter int ADDR_BASE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_in_valid,
  output logic              key_in_ready,
  input  logic [1:0]        key_in_mode,
  input  logic [255:0]      key_in,
  output logic              key_err,
  output logic              rk_valid,
  output logic [ADDR_W-1:0] rk_addr,
  output logic [127:0]      rk_data,
  output logic              key_loaded
);

  localparam logic [3:0] NK_MAX = 4'(MAX_NK);

  ks_state_t state, state_nxt;

  logic             accept;
  logic             mode_ok;
  logic [255:0]     key_sh;
  logic [7:0][31:0] hist;
  logic [95:0]      acc;
  logic [3:0]       nk_r;
  logic [5:0]       idx;
  logic [5:0]       last_idx;
  logic [2:0]       phase;
  logic [7:0]       rcon;
  logic [31:0]      prev;
  logic [31:0]      back;
  logic [31:0]      sub_in;
  logic [31:0]      sub_out;
  logic [31:0]      t;
  logic [31:0]      w_new;

  assign key_in_ready = (state == ST_IDLE)
                     || (state == ST_DONE);
  assign accept  = key_in_valid && key_in_ready;
  assign mode_ok = (key_in_mode != 2'b11)
                && (nk_of(key_in_mode) <= NK_MAX);

  assign prev   = hist[0];
  assign back   = hist[3'(nk_r - 4'd1)];
  assign sub_in = (phase == 3'd0)
                ? {prev[23:0], prev[31:24]} : prev;

  for (genvar g = 0; g < 4; g++) begin : g_sub
    aes_sbox u_sbox (
      .a (sub_in[8*g +: 8]),
      .s (sub_out[8*g +: 8])
    );
  end

  // next schedule word from the history window
  always_comb begin
    t = prev;
    unique case (1'b1)
      (phase == 3'd0):
        t = sub_out ^ {rcon, 24'h0};
      (nk_r == 4'd8 && phase == 3'd4):
        t = sub_out;
      default: ;
    endcase
    if (idx < {2'b00, nk_r}) w_new = key_sh[255:224];
    else                     w_new = back ^ t;
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE:
        if (accept && mode_ok) state_nxt = ST_GEN;
      ST_GEN:
        if (idx == last_idx) state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // key latch, word generation and round-key output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_sh     <= '0;
      hist       <= '0;
      acc        <= '0;
      nk_r       <= '0;
      idx        <= '0;
      last_idx   <= '0;
      phase      <= '0;
      rcon       <= '0;
      key_err    <= 1'b0;
      rk_valid   <= 1'b0;
      rk_addr    <= '0;
      rk_data    <= '0;
      key_loaded <= 1'b0;
    end else begin
      rk_valid <= 1'b0;
      key_err  <= 1'b0;
      if (accept) begin
        if (mode_ok) begin
          key_sh     <= key_in;
          nk_r       <= nk_of(key_in_mode);
          last_idx   <= {nr_of(key_in_mode), 2'b11};
          idx        <= '0;
          phase      <= '0;
          rcon       <= RCON_INIT;
          key_loaded <= 1'b0;
        end else begin
          key_err <= 1'b1;
        end
      end else if (state == ST_GEN) begin
        key_sh <= key_sh << 32;
        hist   <= {hist[6:0], w_new};
        acc    <= {acc[63:0], w_new};
        idx    <= idx + 6'd1;
        if (phase == 3'(nk_r - 4'd1)) phase <= '0;
        else                          phase <= phase + 3'd1;
        if (phase == 3'd0 && idx >= {2'b00, nk_r})
          rcon <= xtime(rcon);
        if (idx[1:0] == 2'b11) begin
          rk_valid <= 1'b1;
          rk_data  <= {acc, w_new};
          rk_addr  <= ADDR_W'(ADDR_BASE)
                    + ADDR_W'(idx[5:2]);
        end
        if (idx == last_idx) key_loaded <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Scoreboard bench for aes_key_schedule using
// FIPS-197 appendix A key-expansion vectors.
module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_in_valid = 1'b0;
  logic         key_in_ready;
  logic [1:0]   key_in_mode = 2'b00;
  logic [255:0] key_in = '0;
  logic         key_err;
  logic         rk_valid;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;
  logic         key_loaded;

  logic         valid4 = 1'b0;
  logic         ready4;
  logic [1:0]   mode4 = 2'b00;
  logic         err4;
  logic         rk_valid4;
  logic [3:0]   rk_addr4;
  logic [127:0] rk_data4;
  logic         loaded4;

  localparam logic [255:0] K128 =
    256'h2b7e1516_28aed2a6_abf71588_09cf4f3c_deadbeef_01234567_89abcdef_55aa55aa;
  localparam logic [255:0] K192 =
    256'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b_cafef00d_12345678;
  localparam logic [255:0] K256 =
    256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;

  aes_key_schedule dut (
    .clk          (clk),
    .rst          (rst),
    .key_in_valid (key_in_valid),
    .key_in_ready (key_in_ready),
    .key_in_mode  (key_in_mode),
    .key_in       (key_in),
    .key_err      (key_err),
    .rk_valid     (rk_valid),
    .rk_addr      (rk_addr),
    .rk_data      (rk_data),
    .key_loaded   (key_loaded)
  );

  aes_key_schedule #(.MAX_NK(4)) dut4 (
    .clk          (clk),
    .rst          (rst),
    .key_in_valid (valid4),
    .key_in_ready (ready4),
    .key_in_mode  (mode4),
    .key_in       (key_in),
    .key_err      (err4),
    .rk_valid     (rk_valid4),
    .rk_addr      (rk_addr4),
    .rk_data      (rk_data4),
    .key_loaded   (loaded4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cycle;
    int           addr;
    logic [127:0] data;
    bit           chk;
  } exp_t;

  exp_t sb[$];
  int nvec = 0;
  int nerr = 0;
  int err_pulses = 0;
  int strobes4 = 0;

  task automatic chk_i(input string nm, input int act, input int want);
    nvec++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  task automatic chk_d(input string nm, input logic [127:0] act, input logic [127:0] want);
    nvec++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // monitor: every strobe pops one expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rk_valid) begin
      if (sb.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_strobe: addr %0d at cycle %0d", rk_addr, cyc);
      end else begin
        e = sb.pop_front();
        chk_i("strobe_cycle", cyc, e.cycle);
        chk_i("strobe_addr", int'(rk_addr), e.addr);
        if (e.chk) chk_d("strobe_data", rk_data, e.data);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && key_err) err_pulses++;
    if (!rst && rk_valid4) strobes4++;
  end

  function automatic int nr_for(input logic [1:0] m);
    if (m == 2'd0) return 10;
    if (m == 2'd1) return 12;
    return 14;
  endfunction

  task automatic push_sched(input logic [1:0] m, input int t,
                            input logic [255:0] key, input int maxk);
    exp_t e;
    int nr;
    nr = nr_for(m);
    for (int k = 0; k <= nr && k <= maxk; k++) begin
      e.cycle = t + 5 + 4 * k;
      e.addr  = 1 + k;
      e.chk   = 1'b0;
      e.data  = '0;
      if (k == 0) begin
        e.chk = 1'b1; e.data = key[255:128];
      end
      if (m == 2'd0 && k == 1) begin
        e.chk = 1'b1;
        e.data = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
      end
      if (m == 2'd0 && k == 10) begin
        e.chk = 1'b1;
        e.data = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
      end
      if (m == 2'd1 && k == 12) begin
        e.chk = 1'b1;
        e.data = 128'he98ba06f_448c773c_8ecc7204_01002202;
      end
      if (m == 2'd2 && k == 1) begin
        e.chk = 1'b1; e.data = key[127:0];
      end
      if (m == 2'd2 && k == 14) begin
        e.chk = 1'b1;
        e.data = 128'hfe4890d1_e6188d0b_046df344_706c631e;
      end
      sb.push_back(e);
    end
  endtask

  task automatic at_cycle(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic offer(input logic [1:0] m, input logic [255:0] k, output int t);
    @(posedge clk); #1;
    key_in_valid = 1'b1;
    key_in_mode  = m;
    key_in       = k;
    t = cyc;
    @(posedge clk); #1;
    key_in_valid = 1'b0;
  endtask

  task automatic wait_done(input logic [1:0] m, input int t);
    int w;
    w = 4 * (nr_for(m) + 1);
    at_cycle(t + w);
    chk_i("loaded_before_end", int'(key_loaded), 0);
    at_cycle(t + w + 1);
    chk_i("loaded_at_end", int'(key_loaded), 1);
    chk_i("ready_at_end", int'(key_in_ready), 1);
    at_cycle(t + w + 2);
    chk_i("sb_drained", sb.size(), 0);
  endtask

  task automatic run_full(input logic [1:0] m, input logic [255:0] k);
    int t;
    offer(m, k, t);
    push_sched(m, t, k, 99);
    wait_done(m, t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_i("rst_ready", int'(key_in_ready), 1);
    chk_i("rst_valid", int'(rk_valid), 0);
    chk_i("rst_addr", int'(rk_addr), 0);
    chk_d("rst_data", rk_data, '0);
    chk_i("rst_loaded", int'(key_loaded), 0);
    chk_i("rst_err", int'(key_err), 0);
    rst = 1'b0;

    run_full(2'd0, K128);

    offer(2'b11, K256, t);
    at_cycle(t + 1);
    chk_i("err_done_pulse", int'(key_err), 1);
    chk_i("err_done_loaded", int'(key_loaded), 1);
    chk_i("err_done_ready", int'(key_in_ready), 1);
    at_cycle(t + 2);
    chk_i("err_done_clear", int'(key_err), 0);

    offer(2'd2, K256, t);
    push_sched(2'd2, t, K256, 99);
    at_cycle(t + 1);
    chk_i("rekey_loaded_drop", int'(key_loaded), 0);
    at_cycle(t + 9);
    @(posedge clk); #1;
    key_in_valid = 1'b1;
    key_in_mode  = 2'd0;
    key_in       = K128;
    @(negedge clk);
    chk_i("gen_ready_low", int'(key_in_ready), 0);
    repeat (3) @(posedge clk);
    #1;
    key_in_valid = 1'b0;
    wait_done(2'd2, t);

    run_full(2'd1, K192);

    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    offer(2'b11, K128, t);
    at_cycle(t + 1);
    chk_i("err_idle_pulse", int'(key_err), 1);
    chk_i("err_idle_ready", int'(key_in_ready), 1);
    at_cycle(t + 2);
    chk_i("err_idle_clear", int'(key_err), 0);
    at_cycle(t + 10);
    chk_i("err_idle_loaded", int'(key_loaded), 0);

    @(posedge clk); #1;
    valid4 = 1'b1;
    mode4  = 2'd2;
    key_in = K256;
    t = cyc;
    @(posedge clk); #1;
    valid4 = 1'b0;
    at_cycle(t + 1);
    chk_i("nk4_err", int'(err4), 1);
    chk_i("nk4_ready", int'(ready4), 1);
    at_cycle(t + 8);
    chk_i("nk4_ready_later", int'(ready4), 1);

    offer(2'd0, K128, t);
    push_sched(2'd0, t, K128, 3);
    at_cycle(t + 19);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_i("midrst_valid", int'(rk_valid), 0);
    chk_i("midrst_addr", int'(rk_addr), 0);
    chk_d("midrst_data", rk_data, '0);
    chk_i("midrst_loaded", int'(key_loaded), 0);
    chk_i("midrst_ready", int'(key_in_ready), 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    chk_i("midrst_drained", sb.size(), 0);
    run_full(2'd0, K128);

    repeat (4) @(posedge clk);
    chk_i("err_pulse_count", err_pulses, 2);
    chk_i("nk4_no_strobes", strobes4, 0);
    chk_i("final_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
